// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// working on operand magnitudes, with sign fix-up in a final cycle before the result is presented.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic              r_busy;
    logic              r_done;
    logic [2:0]        r_op;
    logic              r_sa;
    logic              r_sb;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_sign_a_en;
    logic              w_sign_b_en;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_remf;
    logic [XLEN-1:0]   w_fix_res;

    // Operand decode: signedness, magnitudes and the divide cases that skip iteration
    always_comb begin
        w_accept    = (r_state == S_IDLE) && start && !flush;
        w_sign_a_en = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        w_sign_b_en = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        w_sa        = w_sign_a_en && rs1[XLEN-1];
        w_sb        = w_sign_b_en && rs2[XLEN-1];
        w_mag_a     = w_sa ? neg_x(rs1) : rs1;
        w_mag_b     = w_sb ? neg_x(rs2) : rs2;
        w_div_zero  = funct3[2] && (rs2 == {XLEN{1'b0}});
        w_div_ovf   = funct3[2] && !funct3[0] &&
                      (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
        w_special   = w_div_zero || w_div_ovf;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? rs1 : {XLEN{1'b1}};
        end else begin
            // Overflow: quotient is the dividend itself, remainder is zero
            w_special_res = funct3[1] ? {XLEN{1'b0}} : rs1;
        end
    end

    // Iteration datapath: one multiplier add-shift step and one restoring divide step
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
        w_div_shift = {r_rem, r_a[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
        w_qbit      = !w_div_diff[XLEN];
    end

    // Sign fix-up and result select for the FIXUP cycle
    always_comb begin
        w_prod = (r_sa ^ r_sb) ? neg_2x(r_acc) : r_acc;
        w_quo  = (r_sa ^ r_sb) ? neg_x(r_a) : r_a;
        w_remf = r_sa ? neg_x(r_rem) : r_rem;
        case (r_op)
            3'b000:                  w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:          w_fix_res = w_quo;
            3'b110, 3'b111:          w_fix_res = w_remf;
            default:                 w_fix_res = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush returns to IDLE from any state
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next = w_special ? S_DONE : S_CALC;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_cnt == CW'(XLEN-1)) begin
                        w_next = S_FIXUP;
                    end else begin
                        w_next = S_CALC;
                    end
                end
                S_FIXUP: w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Operand capture, iteration registers and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 3'b000;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_a      <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_rem    <= {XLEN{1'b0}};
            r_result <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= funct3;
                        r_sa  <= w_sa;
                        r_sb  <= w_sb;
                        r_a   <= w_mag_a;
                        r_b   <= w_mag_b;
                        r_cnt <= {CW{1'b0}};
                        r_acc <= {(2*XLEN){1'b0}};
                        r_rem <= {XLEN{1'b0}};
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_op[2]) begin
                        // r_a doubles as the dividend shifter and the quotient accumulator
                        r_rem <= w_qbit ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
                        r_a   <= {r_a[XLEN-2:0], w_qbit};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                        r_b   <= {1'b0, r_b[XLEN-1:1]};
                    end
                end
                S_FIXUP: begin
                    if (!flush) begin
                        r_result <= w_fix_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign stall  = ((r_state == S_IDLE) && start && !flush) ||
                    (r_state == S_CALC) || (r_state == S_FIXUP);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: products, quotients, special
// divide cases, flush, ignored start and reset during an operation.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int vectors = 0;
    int errors  = 0;
    bit seen;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following DONE.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit poke);
        int n;
        bit got;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        #1;
        chk({tag, " stall@start"}, {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'b111;
        rs1    = $urandom;
        rs2    = $urandom;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1'b1;
            end else begin
                chk({tag, " stall@calc"}, {31'd0, stall}, 32'd1);
            end
            if (poke) begin
                start  = (n >= 5 && n < 8);
                funct3 = 3'b101;
                rs1    = 32'd100;
                rs2    = 32'd7;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, n, lat);
        chk({tag, " result"}, result, exp);
        chk({tag, " stall@done"}, {31'd0, stall}, 32'd0);
        chk({tag, " busy@done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
        chk({tag, " busy idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        rs1    = 32'd0;
        rs2    = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset busy",   {31'd0, busy},  32'd0);
        chk("reset done",   {31'd0, done},  32'd0);
        chk("reset stall",  {31'd0, stall}, 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
        run_op("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);
        run_op("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
        run_op("MULHSU -1*2",     3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        run_op("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
        run_op("REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        run_op("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2,        34, 1'b0);
        run_op("DIVU 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
        run_op("REM 5/0",         3'b110, 32'd5,        32'd0,        32'd5,        1,  1'b0);
        run_op("DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
        run_op("REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0);
        run_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       34, 1'b0);

        // Flush ten cycles into a multiply
        funct3 = 3'b000;
        rs1    = 32'd3;
        rs2    = 32'd5;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush busy",   {31'd0, busy},  32'd0);
        chk("flush stall",  {31'd0, stall}, 32'd0);
        chk("flush done",   {31'd0, done},  32'd0);
        chk("flush result", result, 32'd14);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no done after flush", {31'd0, seen}, 32'd0);

        // Start together with flush in IDLE is not accepted
        funct3 = 3'b000;
        rs1    = 32'd2;
        rs2    = 32'd2;
        start  = 1'b1;
        flush  = 1'b1;
        #1;
        chk("start+flush stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("start+flush busy",   {31'd0, busy}, 32'd0);
        chk("start+flush result", result, 32'd14);

        // Start pulses with other operands during CALC must be ignored
        run_op("MUL 6*7 ignored start", 3'b000, 32'd6, 32'd7, 32'd42, 34, 1'b1);

        // Reset during CALC
        funct3 = 3'b000;
        rs1    = 32'd9;
        rs2    = 32'd9;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst mid busy",   {31'd0, busy}, 32'd0);
        chk("rst mid done",   {31'd0, done}, 32'd0);
        chk("rst mid result", result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
